// File: rtl/intr_ctl.sv
// intr_ctl: NSRC-source interrupt controller with per-source enable and
// level/edge mode, software set/clear of edge pending bits, a lowest-index
// claim register and a registered interrupt line.
module intr_ctl #(
    parameter int              NSRC         = 8,
    parameter int              RV           = 16,
    parameter logic [NSRC-1:0] EDGE_DEFAULT = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic [RV-1:0]   io_wdata,
    output logic [RV-1:0]   io_rdata,
    output logic            interrupt
);

    typedef enum logic [3:0] {
        REG_PEND   = 4'd0,
        REG_ENABLE = 4'd1,
        REG_MODE   = 4'd2,
        REG_CLAIM  = 4'd3,
        REG_SWSET  = 4'd4,
        REG_CTRL   = 4'd5
    } reg_e;

    reg_e            sel;
    logic [NSRC-1:0] src_q;
    logic            armed;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] mode;
    logic            gen;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] sw_set;
    logic [NSRC-1:0] sw_clr;
    logic [NSRC-1:0] edge_next;
    logic            claim_valid;
    logic [3:0]      claim_idx;
    logic [15:0]     claim_word;
    logic            unused_wdata;

    assign sel          = reg_e'(io_addr);
    assign unused_wdata = ^io_wdata;

    // Sample the raw sources; armed blocks edge detection for the first
    // cycle after reset so a source held high through reset is not seen
    // as a rising edge while src_q re-samples it.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= '0;
            armed <= 1'b0;
        end else begin
            src_q <= src;
            armed <= 1'b1;
        end
    end

    // Next pending value: edge bits set by rise/SWSET (set beats clear),
    // level bits track the source so they always equal src_q.
    always_comb begin
        rise      = '0;
        sw_set    = '0;
        sw_clr    = '0;
        if (armed) begin
            rise = src & ~src_q;
        end
        if (io_write && sel == REG_SWSET) begin
            sw_set = io_wdata[NSRC-1:0];
        end
        if (io_write && sel == REG_PEND) begin
            sw_clr = io_wdata[NSRC-1:0];
        end
        edge_next = rise | sw_set | (pend & ~sw_clr);
        pend_next = (mode & edge_next) | (~mode & src);
    end

    // Pending register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable <= '0;
            mode   <= EDGE_DEFAULT;
            gen    <= 1'b0;
        end else if (io_write) begin
            case (sel)
                REG_ENABLE: enable <= io_wdata[NSRC-1:0];
                REG_MODE:   mode   <= io_wdata[NSRC-1:0];
                REG_CTRL:   gen    <= io_wdata[0];
                default:    ;
            endcase
        end
    end

    // Registered interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            interrupt <= 1'b0;
        end else begin
            interrupt <= gen & (|(pend & enable));
        end
    end

    // Claim: lowest-numbered pending and enabled source.
    always_comb begin
        claim_valid = 1'b0;
        claim_idx   = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (pend[i] && enable[i] && !claim_valid) begin
                claim_valid = 1'b1;
                claim_idx   = 4'(i);
            end
        end
        claim_word = {claim_valid, 11'b0, claim_idx};
    end

    // Register read mux; unused bits and unmapped addresses read zero.
    always_comb begin
        io_rdata = '0;
        case (sel)
            REG_PEND:   io_rdata[NSRC-1:0] = pend;
            REG_ENABLE: io_rdata[NSRC-1:0] = enable;
            REG_MODE:   io_rdata[NSRC-1:0] = mode;
            REG_CLAIM:  io_rdata           = RV'(claim_word);
            REG_CTRL:   io_rdata[0]        = gen;
            default:    io_rdata           = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctl.sv
// tb_intr_ctl: directed scenarios plus randomized traffic, every cycle
// compared against a per-source behavioural model of the controller.
`timescale 1ns/1ps
module tb_intr_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  src;
    logic [3:0]  io_addr;
    logic        io_write;
    logic [15:0] io_wdata;
    logic [15:0] rdata8;
    logic [15:0] rdata4;
    logic        irq8;
    logic        irq4;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [7:0] m_pend, m_en, m_mode, m_prev;
    logic       m_gen, m_irq, m_fresh;

    // last values read back from the DUT
    logic [15:0] r_pend, r_claim, r_pend4;
    logic        r_irq;

    intr_ctl #(.NSRC(8), .RV(16), .EDGE_DEFAULT(8'h81)) dut (
        .clk(clk), .reset(reset), .src(src), .io_addr(io_addr),
        .io_write(io_write), .io_wdata(io_wdata), .io_rdata(rdata8),
        .interrupt(irq8)
    );

    intr_ctl #(.NSRC(4), .RV(16), .EDGE_DEFAULT(4'h1)) dut4 (
        .clk(clk), .reset(reset), .src(src[3:0]), .io_addr(io_addr),
        .io_write(io_write), .io_wdata(io_wdata), .io_rdata(rdata4),
        .interrupt(irq4)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_claim();
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && m_en[i]) return 16'h8000 | 16'(i);
        end
        return 16'h0000;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic rst, input logic [7:0] s, input logic wr,
                              input logic [3:0] a, input logic [15:0] d);
        logic new_irq;
        logic rose, sset, wclr;
        if (rst) begin
            m_pend = '0; m_en = '0; m_mode = 8'h81; m_gen = 1'b0;
            m_irq = 1'b0; m_prev = '0; m_fresh = 1'b1;
            return;
        end
        new_irq = m_gen && ((m_pend & m_en) != 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
                rose = s[i] && !m_prev[i] && !m_fresh;
                sset = wr && (a == 4'd4) && d[i];
                wclr = wr && (a == 4'd0) && d[i];
                if (rose || sset) m_pend[i] = 1'b1;
                else if (wclr)    m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = s[i];
            end
        end
        if (wr) begin
            if (a == 4'd1) m_en   = d[7:0];
            if (a == 4'd2) m_mode = d[7:0];
            if (a == 4'd5) m_gen  = d[0];
        end
        m_prev  = s;
        m_fresh = 1'b0;
        m_irq   = new_irq;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] v, output logic [15:0] v4);
        io_addr = a;
        #1;
        v  = rdata8;
        v4 = rdata4;
    endtask

    task automatic compare_all();
        logic [15:0] v, v4;
        logic [3:0]  hi;
        rd(4'd0, v, v4);
        r_pend = v; r_pend4 = v4;
        check("pend", v, {8'h00, m_pend});
        check("pend4", v4, {12'h000, m_pend[3:0]});
        rd(4'd1, v, v4);
        check("enable", v, {8'h00, m_en});
        check("enable4", v4, {12'h000, m_en[3:0]});
        rd(4'd2, v, v4);
        check("mode", v, {8'h00, m_mode});
        rd(4'd3, v, v4);
        r_claim = v;
        check("claim", v, exp_claim());
        rd(4'd4, v, v4);
        check("swset_rd", v, 16'h0000);
        rd(4'd5, v, v4);
        check("ctrl", v, {15'h0000, m_gen});
        hi = 4'($urandom_range(6, 15));
        rd(hi, v, v4);
        check("unmapped_rd", v, 16'h0000);
        r_irq = irq8;
        check("interrupt", {15'h0000, irq8}, {15'h0000, m_irq});
    endtask

    task automatic step(input logic rst, input logic [7:0] s, input logic wr,
                        input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        reset = rst; src = s; io_write = wr; io_addr = a; io_wdata = d;
        @(posedge clk);
        model_edge(rst, s, wr, a, d);
        #1;
        io_write = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n, input logic [7:0] s);
        repeat (n) step(1'b0, s, 1'b0, 4'd0, 16'h0000);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [7:0] s);
        step(1'b0, s, 1'b1, a, d);
    endtask

    initial begin
        reset = 1'b1; src = '0; io_addr = '0; io_write = 1'b0; io_wdata = '0;
        m_pend = '0; m_en = '0; m_mode = 8'h81; m_prev = '0;
        m_gen = 1'b0; m_irq = 1'b0; m_fresh = 1'b1;
        step(1'b1, 8'h00, 1'b0, 4'd0, 16'h0000);
        step(1'b1, 8'h00, 1'b0, 4'd0, 16'h0000);
        check("reset_claim", r_claim, 16'h0000);

        // level source
        wr(4'd2, 16'h0000, 8'h00);
        wr(4'd1, 16'h0004, 8'h00);
        wr(4'd5, 16'h0001, 8'h00);
        idle(2, 8'h04);
        check("t1_irq", {15'h0, r_irq}, 16'h0001);
        check("t1_claim", r_claim, 16'h8002);
        wr(4'd0, 16'h0004, 8'h04);
        check("t1_pend_w1c_ignored", r_pend, 16'h0004);
        idle(2, 8'h00);
        check("t1_irq_drop", {15'h0, r_irq}, 16'h0000);

        // edge source
        wr(4'd2, 16'h0001, 8'h00);
        wr(4'd1, 16'h0001, 8'h00);
        idle(1, 8'h01);
        idle(2, 8'h00);
        check("t2_pend_held", r_pend, 16'h0001);
        wr(4'd0, 16'h0001, 8'h00);
        check("t2_pend_clr", r_pend, 16'h0000);
        idle(1, 8'h00);
        check("t2_irq_clr", {15'h0, r_irq}, 16'h0000);

        // priority
        wr(4'd2, 16'h00FF, 8'h00);
        wr(4'd1, 16'h0028, 8'h00);
        wr(4'd4, 16'h0028, 8'h00);
        check("t3_claim3", r_claim, 16'h8003);
        wr(4'd0, 16'h0008, 8'h00);
        check("t3_claim5", r_claim, 16'h8005);
        wr(4'd1, 16'h0000, 8'h00);
        check("t3_claim_none", r_claim, 16'h0000);
        idle(1, 8'h00);
        check("t3_irq", {15'h0, r_irq}, 16'h0000);

        // collision and software set
        wr(4'd0, 16'h00FF, 8'h00);
        wr(4'd0, 16'h0002, 8'h02);
        check("t4_set_wins", r_pend & 16'h0002, 16'h0002);
        wr(4'd4, 16'h0080, 8'h00);
        check("t4_swset7", r_pend & 16'h0080, 16'h0080);
        wr(4'd2, 16'h007F, 8'h00);
        wr(4'd4, 16'h0080, 8'h00);
        check("t4_swset_level", r_pend & 16'h0080, 16'h0000);

        // gating and reset
        wr(4'd2, 16'h00FF, 8'h00);
        wr(4'd1, 16'h00FF, 8'h00);
        wr(4'd5, 16'h0000, 8'h00);
        wr(4'd4, 16'h0001, 8'h00);
        idle(2, 8'h00);
        check("t5_gated", {15'h0, r_irq}, 16'h0000);
        wr(4'd5, 16'h0001, 8'h00);
        idle(1, 8'h00);
        check("t5_ungated", {15'h0, r_irq}, 16'h0001);
        step(1'b1, 8'h01, 1'b0, 4'd0, 16'h0000);
        step(1'b1, 8'h01, 1'b0, 4'd0, 16'h0000);
        idle(3, 8'h01);
        check("t5_no_edge_after_reset", r_pend, 16'h0000);

        // unmapped writes
        wr(4'd1, 16'h00F0, 8'h01);
        wr(4'd4, 16'h0030, 8'h01);
        for (int a = 6; a < 16; a++) wr(4'(a), 16'hFFFF, 8'h01);
        check("t6_pend4_width", r_pend4 & 16'hFFF0, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic [3:0]  a;
            logic [15:0] d;
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
            d = 16'($urandom);
            if ($urandom_range(0, 59) == 0)
                step(1'b1, 8'($urandom), 1'b0, 4'd0, 16'h0000);
            else
                step(1'b0, 8'($urandom), ($urandom_range(0, 2) == 0), a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
